alu_op_issuer: RTL and testbench

Sequential front-end that accepts ALU operation requests over a valid/ready handshake and drives the 4-bit combinational ALU's A, B and opcode ports. It holds the operands stable for a programmable settle time, samples result, carry-out and zero, and returns them over a second valid/ready handshake. It sits between the control path and the ALU and replaces direct combinational driving of the ALU.

---
 rtl/alu_op_issuer.sv | 135 +++++++++++++
 tb/tb_alu_op_issuer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// ----------------------------------------------------------------------------
// alu_op_issuer: valid/ready front-end that drives a 4-bit ALU, waits a settle
// time, samples result/flags and returns them over a response handshake.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_op_issuer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [2:0] req_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [3:0] alu_result,
  input  logic       alu_carry_out,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic [2:0] rsp_op,
  output logic       rsp_err,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       op_valid;
  logic       accept;
  logic       sample;
  logic       consume;

  assign op_valid = (req_op <= 3'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    consume   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          // invalid opcodes never touch the ALU and answer immediately
          state_nxt = op_valid ? DRIVE : RESP;
        end
      end
      DRIVE: begin
        if (settle_cnt == 4'd1) begin
          sample    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          consume   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_opcode <= 3'd0;
      settle_cnt <= 4'd0;
      rsp_result <= 4'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_op     <= 3'd0;
      rsp_err    <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      if (accept && op_valid) begin
        alu_a      <= req_a;
        alu_b      <= req_b;
        alu_opcode <= req_op;
        settle_cnt <= 4'(SETTLE_CYCLES);
      end else if (state == DRIVE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end

      if (accept && !op_valid) begin
        rsp_result <= 4'd0;
        rsp_carry  <= 1'b0;
        rsp_zero   <= 1'b0;
        rsp_op     <= req_op;
        rsp_err    <= 1'b1;
      end else if (sample) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry_out;
        rsp_zero   <= alu_zero;
        rsp_op     <= alu_opcode;
        rsp_err    <= 1'b0;
      end

      if (consume) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_issuer: two instances (settle 1 and 4) checked every cycle against
// a timing-level model, plus directed literal checks.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_issuer;

  localparam int S0 = 1;
  localparam int S1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, req_valid, req_ready, rsp_ready, rsp_valid;
  logic [1:0]      rsp_carry, rsp_zero, rsp_err, alu_carry_out, alu_zero;
  logic [1:0][3:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [1:0][2:0] req_op, alu_opcode, rsp_op;
  logic [1:0][7:0] op_count;
  logic [1:0]      ovr_en, ovr_c, ovr_z;
  logic [1:0][3:0] ovr_res;

  // bench ALU: add, sub, and, or, xor; {carry, result}
  function automatic logic [4:0] alu_calc(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return 5'd0;
    endcase
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    logic [4:0] calc;
    assign calc             = alu_calc(alu_a[i], alu_b[i], alu_opcode[i]);
    assign alu_result[i]    = ovr_en[i] ? ovr_res[i] : calc[3:0];
    assign alu_carry_out[i] = ovr_en[i] ? ovr_c[i]   : calc[4];
    assign alu_zero[i]      = ovr_en[i] ? ovr_z[i]   : (calc[3:0] == 4'd0);

    alu_op_issuer #(.SETTLE_CYCLES(i == 0 ? S0 : S1)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n[i]),
      .req_valid     (req_valid[i]),
      .req_ready     (req_ready[i]),
      .req_a         (req_a[i]),
      .req_b         (req_b[i]),
      .req_op        (req_op[i]),
      .alu_a         (alu_a[i]),
      .alu_b         (alu_b[i]),
      .alu_opcode    (alu_opcode[i]),
      .alu_result    (alu_result[i]),
      .alu_carry_out (alu_carry_out[i]),
      .alu_zero      (alu_zero[i]),
      .rsp_valid     (rsp_valid[i]),
      .rsp_ready     (rsp_ready[i]),
      .rsp_result    (rsp_result[i]),
      .rsp_carry     (rsp_carry[i]),
      .rsp_zero      (rsp_zero[i]),
      .rsp_op        (rsp_op[i]),
      .rsp_err       (rsp_err[i]),
      .op_count      (op_count[i])
    );
  end

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a request occupies the block from acceptance until its response is
  // consumed; a valid op's response appears SETTLE edges after acceptance.
  int   cyc = 0;
  bit   m_busy [2] = '{0, 0};
  bit   m_pend [2] = '{0, 0};
  int   m_due  [2] = '{0, 0};
  int   m_a    [2] = '{0, 0};
  int   m_b    [2] = '{0, 0};
  int   m_opc  [2] = '{0, 0};
  int   m_res  [2] = '{0, 0};
  int   m_c    [2] = '{0, 0};
  int   m_z    [2] = '{0, 0};
  int   m_op   [2] = '{0, 0};
  int   m_err  [2] = '{0, 0};
  int   m_cnt  [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        m_busy[k] = 0; m_pend[k] = 0;
        m_a[k] = 0; m_b[k] = 0; m_opc[k] = 0;
        m_res[k] = 0; m_c[k] = 0; m_z[k] = 0; m_op[k] = 0; m_err[k] = 0;
        m_cnt[k] = 0;
      end else if (!m_busy[k]) begin
        if (req_valid[k]) begin
          m_busy[k] = 1;
          if (req_op[k] <= 3'd4) begin
            m_a[k] = req_a[k]; m_b[k] = req_b[k]; m_opc[k] = req_op[k];
            m_pend[k] = 1;
            m_due[k]  = cyc + (k == 0 ? S0 : S1);
          end else begin
            m_pend[k] = 0;
            m_res[k] = 0; m_c[k] = 0; m_z[k] = 0; m_op[k] = req_op[k]; m_err[k] = 1;
          end
        end
      end else if (m_pend[k]) begin
        if (cyc == m_due[k]) begin
          m_pend[k] = 0;
          m_res[k] = alu_result[k]; m_c[k] = alu_carry_out[k]; m_z[k] = alu_zero[k];
          m_op[k] = m_opc[k]; m_err[k] = 0;
        end
      end else if (rsp_ready[k]) begin
        m_busy[k] = 0;
        m_cnt[k]  = (m_cnt[k] + 1) % 256;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d req_ready", k),  req_ready[k],  !m_busy[k]);
        chk($sformatf("u%0d rsp_valid", k),  rsp_valid[k],  m_busy[k] && !m_pend[k]);
        chk($sformatf("u%0d alu_a", k),      alu_a[k],      m_a[k]);
        chk($sformatf("u%0d alu_b", k),      alu_b[k],      m_b[k]);
        chk($sformatf("u%0d alu_opcode", k), alu_opcode[k], m_opc[k]);
        chk($sformatf("u%0d rsp_result", k), rsp_result[k], m_res[k]);
        chk($sformatf("u%0d rsp_carry", k),  rsp_carry[k],  m_c[k]);
        chk($sformatf("u%0d rsp_zero", k),   rsp_zero[k],   m_z[k]);
        chk($sformatf("u%0d rsp_op", k),     rsp_op[k],     m_op[k]);
        chk($sformatf("u%0d rsp_err", k),    rsp_err[k],    m_err[k]);
        chk($sformatf("u%0d op_count", k),   op_count[k],   m_cnt[k]);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input int k, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op);
    bit ok = 0;
    req_a[k] = a; req_b[k] = b; req_op[k] = op; req_valid[k] = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (req_ready[k]) ok = 1;
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    if (!ok) chk("issue timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int k, output int n);
    n = 0;
    while (!rsp_valid[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[k]) chk("rsp timeout", 0, 1);
  endtask

  task automatic consume(input int k);
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  initial begin
    int n;
    int got;
    rst_n = '0; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_op = '0;
    ovr_en = '0; ovr_c = '0; ovr_z = '0; ovr_res = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n = 2'b11;
    @(negedge clk);

    // reset state and idle
    chk("reset req_ready", req_ready, 2'b11);
    chk("reset op_count", op_count[0], 0);
    chk("reset alu_a", alu_a[1], 0);
    got = 0;
    repeat (20) begin
      if (rsp_valid != 2'b00) got++;
      @(negedge clk);
    end
    chk("idle rsp_valid count", got, 0);

    // settle 1: 0111 + 1011 = 1_0010
    issue(0, 4'b0111, 4'b1011, 3'b000);
    chk("t1 alu_a", alu_a[0], 4'b0111);
    chk("t1 alu_b", alu_b[0], 4'b1011);
    chk("t1 alu_opcode", alu_opcode[0], 3'b000);
    wait_rsp(0, n);
    chk("t1 latency", n, 1);
    chk("t1 result", rsp_result[0], 4'b0010);
    chk("t1 carry", rsp_carry[0], 1);
    chk("t1 zero", rsp_zero[0], 0);
    chk("t1 op", rsp_op[0], 3'b000);
    consume(0);
    chk("t1 op_count", op_count[0], 1);
    chk("t1 rsp_valid dropped", rsp_valid[0], 0);

    // invalid opcode answers immediately, ALU ports untouched
    issue(0, 4'h3, 4'h3, 3'b110);
    wait_rsp(0, n);
    chk("inv latency", n, 0);
    chk("inv err", rsp_err[0], 1);
    chk("inv result", rsp_result[0], 4'b0000);
    chk("inv op", rsp_op[0], 3'b110);
    chk("inv alu_a held", alu_a[0], 4'b0111);
    chk("inv alu_b held", alu_b[0], 4'b1011);
    consume(0);
    chk("inv op_count", op_count[0], 2);

    // backpressure: 5 - 3 = 1_0010, then a pending 1001 & 0110 = 0000
    issue(0, 4'h5, 4'h3, 3'b001);
    wait_rsp(0, n);
    req_a[0] = 4'h9; req_b[0] = 4'h6; req_op[0] = 3'b010; req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp req_ready", req_ready[0], 0);
      chk("bp rsp_valid", rsp_valid[0], 1);
      chk("bp result", rsp_result[0], 4'b0010);
      chk("bp carry", rsp_carry[0], 1);
      chk("bp alu_a", alu_a[0], 4'h5);
    end
    consume(0);
    chk("bp op_count", op_count[0], 3);
    chk("bp req_ready after", req_ready[0], 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("bp accepted alu_a", alu_a[0], 4'h9);
    chk("bp accepted opcode", alu_opcode[0], 3'b010);
    wait_rsp(0, n);
    chk("bp2 latency", n, 1);
    chk("bp2 result", rsp_result[0], 4'b0000);
    chk("bp2 zero", rsp_zero[0], 1);
    consume(0);

    // settle 4: ALU output changes at the last settle cycle
    ovr_en[1] = 1'b1; ovr_res[1] = 4'b0001; ovr_c[1] = 1'b0; ovr_z[1] = 1'b0;
    issue(1, 4'hA, 4'h5, 3'b000);
    for (int j = 1; j <= 3; j++) begin
      chk("s4 rsp_valid early", rsp_valid[1], 0);
      chk("s4 alu_a stable", alu_a[1], 4'hA);
      chk("s4 alu_b stable", alu_b[1], 4'h5);
      @(negedge clk);
    end
    ovr_res[1] = 4'b1010; ovr_c[1] = 1'b1;
    chk("s4 rsp_valid early", rsp_valid[1], 0);
    chk("s4 alu_a stable", alu_a[1], 4'hA);
    @(negedge clk);
    chk("s4 rsp_valid", rsp_valid[1], 1);
    chk("s4 result", rsp_result[1], 4'b1010);
    chk("s4 carry", rsp_carry[1], 1);
    consume(1);
    ovr_en[1] = 1'b0;
    chk("s4 op_count", op_count[1], 1);

    // reset during DRIVE discards the response
    issue(1, 4'h1, 4'h2, 3'b011);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk("mid rst op_count", op_count[1], 0);
    chk("mid rst req_ready", req_ready[1], 1);
    chk("mid rst alu_a", alu_a[1], 0);
    got = 0;
    repeat (8) begin
      if (rsp_valid[1]) got++;
      @(negedge clk);
    end
    chk("mid rst no rsp", got, 0);

    // 256 back-to-back operations wrap op_count
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    req_b[0] = 4'h3; req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    got = 0;
    for (int j = 0; j < 900 && got < 256; j++) begin
      req_a[0]  = 4'(j);
      req_op[0] = 3'(j % 5);
      if (rsp_valid[0]) begin
        got++;
        if (got == 256) begin
          chk("wrap op_count 255", op_count[0], 255);
          req_valid[0] = 1'b0;
        end
      end
      @(negedge clk);
    end
    rsp_ready[0] = 1'b0;
    chk("wrap responses", got, 256);
    chk("wrap op_count 0", op_count[0], 0);
    chk("wrap rsp_valid", rsp_valid[0], 0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
